// File: rtl/offset_window_monitor.sv
`default_nettype none
//==============================================================================
// offset_window_monitor - two offset streams plus a DEPTH-event sliding sum.
// Revision 1.0
//==============================================================================
module offset_window_monitor #(
  parameter int  WIDTH     = 8,
  parameter int  DEPTH     = 4,
  parameter int  OFFSET_B  = 1,
  parameter int  OFFSET_C  = 2,
  parameter int  DEFAULT_B = 0,
  parameter int  DEFAULT_C = -1,
  localparam int SW        = WIDTH + $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] input_a,
  input  logic                    new_input,
  output logic signed [WIDTH-1:0] output_b,
  output logic                    output_b_aktv,
  output logic signed [WIDTH-1:0] output_c,
  output logic                    output_c_aktv,
  output logic signed [SW-1:0]    output_s,
  output logic                    output_s_aktv
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]          CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0]          CNT_B   = CW'(OFFSET_B);
  localparam logic [CW-1:0]          CNT_C   = CW'(OFFSET_C);
  localparam logic signed [WIDTH-1:0] DEF_B  = WIDTH'(DEFAULT_B);
  localparam logic signed [WIDTH-1:0] DEF_C  = WIDTH'(DEFAULT_C);

  generate
    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
      $error("offset_window_monitor: DEPTH must be in 2..16");
    end
    if (OFFSET_B < 1 || OFFSET_B > DEPTH - 1) begin : g_bad_offset_b
      $error("offset_window_monitor: OFFSET_B must be in 1..DEPTH-1");
    end
    if (OFFSET_C < 1 || OFFSET_C > DEPTH - 1) begin : g_bad_offset_c
      $error("offset_window_monitor: OFFSET_C must be in 1..DEPTH-1");
    end
  endgenerate

  logic signed [WIDTH-1:0] hist [DEPTH];
  logic        [CW-1:0]    cnt;
  logic                    accept;
  logic signed [SW-1:0]    a_ext;
  logic signed [SW-1:0]    drop;
  logic signed [SW-1:0]    sum_next;

  assign accept   = en & new_input;
  assign a_ext    = SW'(input_a);
  // The oldest sample leaves the window only once the window is full.
  assign drop     = (cnt == CNT_MAX) ? SW'(hist[DEPTH-1]) : '0;
  assign sum_next = output_s + a_ext - drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (accept) begin
      hist[0] <= input_a;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      output_b      <= '0;
      output_c      <= '0;
      output_s      <= '0;
      output_b_aktv <= 1'b0;
      output_c_aktv <= 1'b0;
      output_s_aktv <= 1'b0;
    end else if (en) begin
      output_b_aktv <= new_input;
      output_c_aktv <= new_input;
      output_s_aktv <= new_input;
      if (new_input) begin
        output_b <= (cnt >= CNT_B) ? hist[OFFSET_B-1] : DEF_B;
        output_c <= (cnt >= CNT_C) ? hist[OFFSET_C-1] : DEF_C;
        output_s <= sum_next;
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire
